simon_sound_arbiter: RTL

Shares the single Simon speaker pin between up to four tone requesters: game sequence playback, button feedback, error buzz and victory jingle. It grants one requester at a time by fixed priority and plays a square-wave tone of the requested half-period for the requested number of milliseconds. It then inserts a fixed silent gap before the next grant. It sits between the game FSM and the `sound` pad output, in the same clock domain, and uses the same `ticks_per_milli` prescale value.

---
 rtl/simon_pkg.sv | 23 ++
 rtl/simon_ms_tick.sv | 33 +++
 rtl/simon_sound_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/simon_pkg.sv
// Shared types and widths for the Simon sound arbiter.
package simon_pkg;

  localparam int NUM_REQ = 4;
  localparam int HALF_W  = 16;
  localparam int DUR_W   = 8;
  localparam int TICKS_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Expand a requester index into a one-hot vector.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] idx);
    logic [NUM_REQ-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/simon_ms_tick.sv
// Millisecond prescaler: pulses tick once every ticks_per_milli enabled
// cycles (0 is treated as 1). clear restarts the count from zero.
module simon_ms_tick
  import simon_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               clear,
  input  logic [TICKS_W-1:0] ticks_per_milli,
  output logic               tick
);

  logic [TICKS_W-1:0] cnt;
  logic [TICKS_W-1:0] last;

  // Terminal count; a prescale of 0 behaves like 1 (tick every cycle).
  always_comb begin
    last = '0;
    if (ticks_per_milli != '0) last = ticks_per_milli - 1'b1;
    tick = enable && (cnt == last);
  end

  // Count enabled cycles, reloading at the terminal count so it never wraps.
  always_ff @(posedge clk) begin
    if (rst || clear)  cnt <= '0;
    else if (enable) begin
      if (tick) cnt <= '0;
      else      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/simon_sound_arbiter.sv
// Fixed-priority arbiter sharing the Simon speaker pin between four tone
// requesters, with a silent gap after every tone.
// Handshake: req[i] is a level; grant[i] is high for the whole tone, done[i]
// pulses in the last cycle of a tone that ran to completion, and dropping
// req[i] during the tone aborts it without done.
module simon_sound_arbiter
  import simon_pkg::*;
#(
  parameter int GAP_MS = 2
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic [TICKS_W-1:0]          ticks_per_milli,
  input  logic                        mute,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*HALF_W-1:0]   tone_half,
  input  logic [NUM_REQ*DUR_W-1:0]    dur_ms,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic                        busy,
  output logic                        sound
);

  state_t             state;
  state_t             state_next;
  logic [1:0]         idx;
  logic [1:0]         pick;
  logic [HALF_W-1:0]  sel_half;
  logic [DUR_W-1:0]   sel_dur;
  logic [HALF_W-1:0]  half_q;
  logic [HALF_W-1:0]  half_cnt;
  logic [TICKS_W-1:0] tpm_q;
  logic [DUR_W-1:0]   dur_cnt;
  logic               tone;
  logic               tick;
  logic               expire;
  logic               start;
  logic               clear;

  // Lowest requesting index wins; select its tone parameters.
  always_comb begin
    pick     = '0;
    sel_half = '0;
    sel_dur  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) pick = 2'(i);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == 2'(i)) begin
        sel_half = tone_half[i*HALF_W +: HALF_W];
        sel_dur  = dur_ms[i*DUR_W +: DUR_W];
      end
    end
  end

  // Next state and outputs. A zero duration expires on the first PLAY cycle;
  // otherwise the tone ends on the ms tick that exhausts the duration.
  always_comb begin
    state_next = state;
    start      = (state == IDLE) && (|req);
    expire     = (state == PLAY) &&
                 ((dur_cnt == '0) || ((dur_cnt == 8'd1) && tick));
    case (state)
      IDLE:    if (start) state_next = PLAY;
      PLAY:    if (expire || !req[idx]) state_next = (GAP_MS == 0) ? IDLE : GAP;
      GAP:     if (tick && (dur_cnt == 8'd1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    clear = (state_next != state);
    grant = (state == PLAY) ? onehot(idx) : '0;
    done  = (expire && !wb_rst_i) ? onehot(idx) : '0;
    busy  = (state != IDLE);
    sound = (state == PLAY) && tone && !mute;
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  // Latch the winner's parameters at grant; later input changes are ignored.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      idx    <= '0;
      half_q <= '0;
      tpm_q  <= '0;
    end else if (start) begin
      idx    <= pick;
      half_q <= sel_half;
      tpm_q  <= ticks_per_milli;
    end
  end

  // Shared ms countdown: tone duration during PLAY, gap length during GAP.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                                dur_cnt <= '0;
    else if (start)                              dur_cnt <= sel_dur;
    else if (state == PLAY && state_next == GAP) dur_cnt <= DUR_W'(GAP_MS);
    else if (tick && dur_cnt != '0)              dur_cnt <= dur_cnt - 1'b1;
  end

  // Square-wave generator; idle at 0 outside PLAY so each tone starts low.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state != PLAY) begin
      half_cnt <= '0;
      tone     <= 1'b0;
    end else if (half_q != '0) begin
      if (half_cnt == half_q - 1'b1) begin
        half_cnt <= '0;
        tone     <= ~tone;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
    end
  end

  simon_ms_tick u_ms_tick (
    .clk             (wb_clk_i),
    .rst             (wb_rst_i),
    .enable          (state != IDLE),
    .clear           (clear),
    .ticks_per_milli (tpm_q),
    .tick            (tick)
  );

endmodule
